// File: rtl/immed_decode_stage.sv
// rtl/immed_decode_stage.sv - RV32I immediate decoder feeding a DEPTH-entry output FIFO.
// Optional illegal-opcode counter enabled by defining IMMED_ERR_CNT_EN.
module immed_decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [31:0]     INSTRUCT,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] OUT_IMM,
  output logic [2:0]      OUT_TYPE,
  output logic [31:0]     OUT_INSTRUCT,
  output logic [15:0]     ERR_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] TYPE_R       = 3'd0;
  localparam logic [2:0] TYPE_I       = 3'd1;
  localparam logic [2:0] TYPE_S       = 3'd2;
  localparam logic [2:0] TYPE_B       = 3'd3;
  localparam logic [2:0] TYPE_U       = 3'd4;
  localparam logic [2:0] TYPE_J       = 3'd5;
  localparam logic [2:0] TYPE_ILLEGAL = 3'd7;

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [XLEN-1:0] imm_mem_q   [DEPTH];
  logic [2:0]      type_mem_q  [DEPTH];
  logic [31:0]     instr_mem_q [DEPTH];

  logic [2:0]      dec_type;
  logic [31:0]     dec_imm32;
  logic [XLEN-1:0] dec_imm;
  logic            push;
  logic            pop;

  assign IN_READY  = (count_q < CW'(DEPTH));
  assign OUT_VALID = (count_q != '0);
  assign push      = IN_VALID & IN_READY;
  assign pop       = OUT_VALID & OUT_READY;

  always_comb begin
    dec_type  = TYPE_ILLEGAL;
    dec_imm32 = '0;
    case (INSTRUCT[6:0])
      7'b0110111, 7'b0010111: begin
        dec_type  = TYPE_U;
        dec_imm32 = {INSTRUCT[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_type  = TYPE_J;
        dec_imm32 = {{12{INSTRUCT[31]}}, INSTRUCT[19:12], INSTRUCT[20],
                     INSTRUCT[30:21], 1'b0};
      end
      7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011, 7'b0001111: begin
        dec_type  = TYPE_I;
        dec_imm32 = {{20{INSTRUCT[31]}}, INSTRUCT[31:20]};
      end
      7'b0100011: begin
        dec_type  = TYPE_S;
        dec_imm32 = {{20{INSTRUCT[31]}}, INSTRUCT[31:25], INSTRUCT[11:7]};
      end
      7'b1100011: begin
        dec_type  = TYPE_B;
        dec_imm32 = {{20{INSTRUCT[31]}}, INSTRUCT[7], INSTRUCT[30:25],
                     INSTRUCT[11:8], 1'b0};
      end
      7'b0110011: begin
        dec_type  = TYPE_R;
      end
      default: begin
        dec_type  = TYPE_ILLEGAL;
      end
    endcase
  end

  // Upper bits always come from INSTRUCT[31]; R and ILLEGAL stay all-zero.
  always_comb begin
    dec_imm = '0;
    if (dec_type != TYPE_R && dec_type != TYPE_ILLEGAL) begin
      dec_imm        = {XLEN{INSTRUCT[31]}};
      dec_imm[31:0]  = dec_imm32;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; count gates visibility of stale entries.
  always_ff @(posedge CLK) begin
    if (push) begin
      imm_mem_q[wr_ptr_q]   <= dec_imm;
      type_mem_q[wr_ptr_q]  <= dec_type;
      instr_mem_q[wr_ptr_q] <= INSTRUCT;
    end
  end

  assign OUT_IMM      = imm_mem_q[rd_ptr_q];
  assign OUT_TYPE     = type_mem_q[rd_ptr_q];
  assign OUT_INSTRUCT = instr_mem_q[rd_ptr_q];

`ifdef IMMED_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push && dec_type == TYPE_ILLEGAL && err_cnt_q != 16'hFFFF) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ERR_CNT = err_cnt_q;
`else
  assign ERR_CNT = '0;
`endif

endmodule

// File: tb/tb_immed_decode_stage.sv
// tb/tb_immed_decode_stage.sv - directed bench for immed_decode_stage at XLEN 32 and 64.
module tb_immed_decode_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic [31:0] INSTRUCT = 32'h0;
  logic        OUT_READY = 1'b0;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [31:0] a_imm;
  logic [63:0] b_imm;
  logic [2:0]  a_type, b_type;
  logic [31:0] a_instr, b_instr;
  logic [15:0] a_err, b_err;

  int pass_cnt = 0;
  int total_cnt = 0;

`ifdef IMMED_ERR_CNT_EN
  localparam logic [15:0] EXP_ERR3 = 16'd3;
`else
  localparam logic [15:0] EXP_ERR3 = 16'd0;
`endif

  always #5 CLK = ~CLK;

  immed_decode_stage #(.XLEN(32), .DEPTH(2)) u32 (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(a_in_ready),
    .INSTRUCT(INSTRUCT), .OUT_VALID(a_out_valid), .OUT_READY(OUT_READY),
    .OUT_IMM(a_imm), .OUT_TYPE(a_type), .OUT_INSTRUCT(a_instr), .ERR_CNT(a_err)
  );

  immed_decode_stage #(.XLEN(64), .DEPTH(2)) u64 (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(b_in_ready),
    .INSTRUCT(INSTRUCT), .OUT_VALID(b_out_valid), .OUT_READY(OUT_READY),
    .OUT_IMM(b_imm), .OUT_TYPE(b_type), .OUT_INSTRUCT(b_instr), .ERR_CNT(b_err)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
    tick(); tick();
    RST = 1'b0;
    tick();
    total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL reset_valid32 got %b exp 0", a_out_valid); else pass_cnt++;
    total_cnt++; if (a_in_ready !== 1'b1) $display("FAIL reset_ready32 got %b exp 1", a_in_ready); else pass_cnt++;
    total_cnt++; if (a_err !== 16'd0) $display("FAIL reset_err32 got %h exp 0", a_err); else pass_cnt++;
    total_cnt++; if (b_out_valid !== 1'b0) $display("FAIL reset_valid64 got %b exp 0", b_out_valid); else pass_cnt++;
    total_cnt++; if (b_in_ready !== 1'b1) $display("FAIL reset_ready64 got %b exp 1", b_in_ready); else pass_cnt++;
    total_cnt++; if (b_err !== 16'd0) $display("FAIL reset_err64 got %h exp 0", b_err); else pass_cnt++;
  endtask

  task automatic test_i_type();
    OUT_READY = 1'b1; IN_VALID = 1'b1; INSTRUCT = 32'hFFF00093;
    tick();
    IN_VALID = 1'b0;
    total_cnt++; if (a_out_valid !== 1'b1) $display("FAIL i_valid got %b exp 1", a_out_valid); else pass_cnt++;
    total_cnt++; if (a_type !== 3'd1) $display("FAIL i_type got %0d exp 1", a_type); else pass_cnt++;
    total_cnt++; if (a_imm !== 32'hFFFFFFFF) $display("FAIL i_imm32 got %h exp ffffffff", a_imm); else pass_cnt++;
    total_cnt++; if (b_imm !== 64'hFFFFFFFFFFFFFFFF) $display("FAIL i_imm64 got %h exp ffffffffffffffff", b_imm); else pass_cnt++;
    total_cnt++; if (a_instr !== 32'hFFF00093) $display("FAIL i_instr got %h exp fff00093", a_instr); else pass_cnt++;
    tick();
    total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL i_drained got %b exp 0", a_out_valid); else pass_cnt++;
  endtask

  task automatic test_u_r();
    OUT_READY = 1'b1; IN_VALID = 1'b1; INSTRUCT = 32'h800002B7;
    tick();
    INSTRUCT = 32'hFFFFFFB3;
    total_cnt++; if (b_type !== 3'd4) $display("FAIL u_type got %0d exp 4", b_type); else pass_cnt++;
    total_cnt++; if (a_imm !== 32'h80000000) $display("FAIL u_imm32 got %h exp 80000000", a_imm); else pass_cnt++;
    total_cnt++; if (b_imm !== 64'hFFFFFFFF80000000) $display("FAIL u_imm64 got %h exp ffffffff80000000", b_imm); else pass_cnt++;
    tick();
    IN_VALID = 1'b0;
    total_cnt++; if (b_type !== 3'd0) $display("FAIL r_type got %0d exp 0", b_type); else pass_cnt++;
    total_cnt++; if (b_imm !== 64'h0) $display("FAIL r_imm64 got %h exp 0", b_imm); else pass_cnt++;
    tick();
  endtask

  task automatic test_b_j_full();
    OUT_READY = 1'b0; IN_VALID = 1'b1; INSTRUCT = 32'hFE000EE3;
    tick();
    INSTRUCT = 32'h800000EF;
    tick();
    total_cnt++; if (b_type !== 3'd3) $display("FAIL b_type got %0d exp 3", b_type); else pass_cnt++;
    total_cnt++; if (b_imm !== 64'hFFFFFFFFFFFFFFFC) $display("FAIL b_imm64 got %h exp fffffffffffffffc", b_imm); else pass_cnt++;
    total_cnt++; if (a_imm !== 32'hFFFFFFFC) $display("FAIL b_imm32 got %h exp fffffffc", a_imm); else pass_cnt++;
    total_cnt++; if (a_in_ready !== 1'b0) $display("FAIL full_ready32 got %b exp 0", a_in_ready); else pass_cnt++;
    total_cnt++; if (b_in_ready !== 1'b0) $display("FAIL full_ready64 got %b exp 0", b_in_ready); else pass_cnt++;
    // Push offered while full with a same-cycle pop must be dropped.
    INSTRUCT = 32'h00100093; OUT_READY = 1'b1;
    tick();
    IN_VALID = 1'b0;
    total_cnt++; if (a_in_ready !== 1'b1) $display("FAIL refuse_ready got %b exp 1", a_in_ready); else pass_cnt++;
    total_cnt++; if (b_out_valid !== 1'b1) $display("FAIL refuse_valid got %b exp 1", b_out_valid); else pass_cnt++;
    total_cnt++; if (b_type !== 3'd5) $display("FAIL j_type got %0d exp 5", b_type); else pass_cnt++;
    total_cnt++; if (b_imm !== 64'hFFFFFFFFFFF00000) $display("FAIL j_imm64 got %h exp fffffffffff00000", b_imm); else pass_cnt++;
    total_cnt++; if (a_imm !== 32'hFFF00000) $display("FAIL j_imm32 got %h exp fff00000", a_imm); else pass_cnt++;
    tick();
    total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL refuse_drop got %b exp 0", a_out_valid); else pass_cnt++;
  endtask

  task automatic test_illegal();
    logic [31:0] words [3];
    words[0] = 32'h8000007F; words[1] = 32'h1234567F; words[2] = 32'hFFFFFFFF;
    OUT_READY = 1'b1; IN_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      INSTRUCT = words[i];
      tick();
      total_cnt++; if (b_type !== 3'd7) $display("FAIL ill_type%0d got %0d exp 7", i, b_type); else pass_cnt++;
      total_cnt++; if (b_imm !== 64'h0) $display("FAIL ill_imm%0d got %h exp 0", i, b_imm); else pass_cnt++;
      total_cnt++; if (a_instr !== words[i]) $display("FAIL ill_instr%0d got %h exp %h", i, a_instr, words[i]); else pass_cnt++;
    end
    IN_VALID = 1'b0; OUT_READY = 1'b0;
    total_cnt++; if (a_err !== EXP_ERR3) $display("FAIL err_cnt32 got %0d exp %0d", a_err, EXP_ERR3); else pass_cnt++;
    total_cnt++; if (b_err !== EXP_ERR3) $display("FAIL err_cnt64 got %0d exp %0d", b_err, EXP_ERR3); else pass_cnt++;
    #2;
    RST = 1'b1;
    #1;
    total_cnt++; if (a_err !== 16'd0) $display("FAIL rst_err got %h exp 0", a_err); else pass_cnt++;
    total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", a_out_valid); else pass_cnt++;
    total_cnt++; if (b_in_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", b_in_ready); else pass_cnt++;
    tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [11:0] k;
    logic [31:0] w;
    logic [63:0] exp64;
    OUT_READY = 1'b1; IN_VALID = 1'b1;
    for (int i = 0; i < 6; i++) begin
      k = 12'hF80 + 12'(i * 37);
      w = {k[11:5], 5'd3, 5'd2, 3'b010, k[4:0], 7'b0100011};
      exp64 = {{52{k[11]}}, k};
      INSTRUCT = w;
      tick();
      total_cnt++; if (b_out_valid !== 1'b1) $display("FAIL wrap_valid%0d got %b exp 1", i, b_out_valid); else pass_cnt++;
      total_cnt++; if (b_type !== 3'd2) $display("FAIL wrap_type%0d got %0d exp 2", i, b_type); else pass_cnt++;
      total_cnt++; if (b_imm !== exp64) $display("FAIL wrap_imm%0d got %h exp %h", i, b_imm, exp64); else pass_cnt++;
      total_cnt++; if (a_imm !== exp64[31:0]) $display("FAIL wrap_imm32_%0d got %h exp %h", i, a_imm, exp64[31:0]); else pass_cnt++;
      total_cnt++; if (b_instr !== w) $display("FAIL wrap_instr%0d got %h exp %h", i, b_instr, w); else pass_cnt++;
    end
    IN_VALID = 1'b0;
    tick();
    total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL wrap_drain got %b exp 0", a_out_valid); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_i_type();
    test_u_r();
    test_b_j_full();
    test_illegal();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
